// File: rtl/cmos_backup_engine_if.sv
// Bus bundle for the CMOS backup engine: control, CMOS RAM port and the
// tx/rx byte streams. The engine side uses the master modport; whatever
// surrounds it (RAM, host link, control logic) uses the slave modport.
interface cmos_backup_engine_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 4
);
  // control
  logic                  start_dump;
  logic                  start_load;
  logic                  abort;
  logic                  busy;
  logic                  done;
  // CMOS RAM port
  logic                  ram_cs;
  logic                  ram_we;
  logic [ADDR_W-1:0]     ram_addr;
  logic [DATA_W-1:0]     ram_wdata;
  logic [DATA_W-1:0]     ram_rdata;
  // dump stream (engine -> sink)
  logic [2*DATA_W-1:0]   tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  // restore stream (source -> engine)
  logic [2*DATA_W-1:0]   rx_data;
  logic                  rx_valid;
  logic                  rx_ready;

  modport master (
    input  start_dump, start_load, abort,
    input  ram_rdata,
    input  tx_ready,
    input  rx_data, rx_valid,
    output busy, done,
    output ram_cs, ram_we, ram_addr, ram_wdata,
    output tx_data, tx_valid,
    output rx_ready
  );

  modport slave (
    output start_dump, start_load, abort,
    output ram_rdata,
    output tx_ready,
    output rx_data, rx_valid,
    input  busy, done,
    input  ram_cs, ram_we, ram_addr, ram_wdata,
    input  tx_data, tx_valid,
    input  rx_ready
  );
endinterface

// File: rtl/cmos_backup_engine.sv
// CMOS backup engine: saves the whole 1024x4 battery-backed RAM as a
// 512-byte stream, or restores it from one. Two nibbles make a byte: the
// low nibble lives at the even address, the high nibble at the odd one.
// Every output is a flop, so the RAM port and handshakes are glitch-free
// and all of them drop immediately on reset.
module cmos_backup_engine #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  cmos_backup_engine_if.master bus
);

  localparam int P_W = ADDR_W - 1;
  localparam logic [P_W-1:0] PTR_MAX = '1;
  localparam logic [P_W-1:0] PTR_ONE = {{(P_W-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    IDLE,
    D_RLO,
    D_RHI,
    D_CAP,
    D_SEND,
    L_WAIT,
    L_WLO,
    L_WHI,
    FIN
  } state_t;

  state_t                state_q, state_d;
  logic [P_W-1:0]        ptr_q, ptr_d;
  logic [DATA_W-1:0]     lo_nib_q, lo_nib_d;
  logic [2*DATA_W-1:0]   rx_byte_q, rx_byte_d;

  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ram_cs_q, ram_cs_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]     ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]     ram_wdata_q, ram_wdata_d;
  logic [2*DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  rx_ready_q, rx_ready_d;

  // State register and byte pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state and pointer: sequencing of dump/load, abort overrides everything outside IDLE
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_dump) begin
          state_d = D_RLO;
          ptr_d   = '0;
        end else if (bus.start_load) begin
          state_d = L_WAIT;
          ptr_d   = '0;
        end
      end
      D_RLO:  state_d = D_RHI;
      D_RHI:  state_d = D_CAP;
      D_CAP:  state_d = D_SEND;
      D_SEND: begin
        if (bus.tx_ready) begin
          if (ptr_q == PTR_MAX) begin
            state_d = FIN;
          end else begin
            state_d = D_RLO;
            ptr_d   = ptr_q + PTR_ONE;
          end
        end
      end
      L_WAIT: begin
        if (bus.rx_valid) begin
          state_d = L_WLO;
        end
      end
      L_WLO:  state_d = L_WHI;
      L_WHI: begin
        if (ptr_q == PTR_MAX) begin
          state_d = FIN;
        end else begin
          state_d = L_WAIT;
          ptr_d   = ptr_q + PTR_ONE;
        end
      end
      FIN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort && (state_q != IDLE)) begin
      state_d = IDLE;
      ptr_d   = ptr_q;
    end
  end

  // Output decode from the upcoming state, so each registered output lines up with its state
  always_comb begin
    lo_nib_d    = lo_nib_q;
    rx_byte_d   = rx_byte_q;
    tx_data_d   = tx_data_q;
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == FIN);
    tx_valid_d  = (state_d == D_SEND);
    rx_ready_d  = (state_d == L_WAIT);
    ram_cs_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;

    // read data for the even address arrives while the odd read is issued
    if (state_q == D_RHI) begin
      lo_nib_d = bus.ram_rdata;
    end
    // tx_data only changes when a new byte is assembled, never while it is offered
    if ((state_q == D_CAP) && (state_d == D_SEND)) begin
      tx_data_d = {bus.ram_rdata, lo_nib_q};
    end
    if ((state_q == L_WAIT) && (state_d == L_WLO)) begin
      rx_byte_d = bus.rx_data;
    end

    unique case (state_d)
      D_RLO: begin
        ram_cs_d   = 1'b1;
        ram_addr_d = {ptr_d, 1'b0};
      end
      D_RHI: begin
        ram_cs_d   = 1'b1;
        ram_addr_d = {ptr_d, 1'b1};
      end
      L_WLO: begin
        ram_cs_d    = 1'b1;
        ram_we_d    = 1'b1;
        ram_addr_d  = {ptr_d, 1'b0};
        ram_wdata_d = rx_byte_d[DATA_W-1:0];
      end
      L_WHI: begin
        ram_cs_d    = 1'b1;
        ram_we_d    = 1'b1;
        ram_addr_d  = {ptr_d, 1'b1};
        ram_wdata_d = rx_byte_d[2*DATA_W-1:DATA_W];
      end
      default: begin
        ram_cs_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo_nib_q    <= '0;
      rx_byte_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      rx_ready_q  <= 1'b0;
    end else begin
      lo_nib_q    <= lo_nib_d;
      rx_byte_q   <= rx_byte_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ram_cs_q    <= ram_cs_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      rx_ready_q  <= rx_ready_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ram_cs    = ram_cs_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.rx_ready  = rx_ready_q;

endmodule
